// File: rtl/hazard_ctrl.sv
// Stall/flush side of the 5-stage pipeline hazard logic: load-use interlock,
// data-memory wait freeze, taken-branch squash, plus saturating perf counters
// and a sticky memory-timeout flag.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic             memRead_EX,
  input  logic [4:0]       rd_EX,
  input  logic             branch_taken_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  logic [0:0]       state;
  logic [CNT_W-1:0] timer;
  logic             freeze, lu, do_flush, do_stall;

  // Hazard conditions; freeze masks everything else so deferred actions
  // fire in the first unfrozen cycle (upstream regs hold their inputs).
  always_comb begin
    freeze   = mem_req_MEM && !mem_ready;
    lu       = memRead_EX && (rd_EX != 5'd0) &&
               ((use_rs1_ID && (rd_EX == rs1_ID)) ||
                (use_rs2_ID && (rd_EX == rs2_ID)));
    do_flush = !freeze && branch_taken_EX;
    do_stall = !freeze && !branch_taken_EX && lu;
  end

  // Pipeline register enables, bubbles and flushes, same-cycle.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (do_flush) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (do_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Wait FSM with saturating timer; timeout is sticky until reset and
  // never aborts the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RUN;
      timer       <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (freeze) begin
            state <= S_WAIT;
            timer <= '0;
          end
        end
        default: begin
          if (timer != TO_VAL) timer <= timer + CNT_W'(1);
          if (freeze && (timer >= TO_VAL - CNT_W'(1))) mem_timeout <= 1'b1;
          // Ready, or a dropped request (protocol violation), ends the wait.
          if (!freeze) state <= S_RUN;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (do_stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      if (freeze   && wait_cnt  != CNT_MAX) wait_cnt  <= wait_cnt  + CNT_W'(1);
      if (do_flush && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
